// File: rtl/id_ex_fifo.sv
// id_ex_fifo: decoupling queue between the ID and EX stages.
// ID pushes one packed ID/EX entry per cycle; EX sees the head entry
// combinationally (show-ahead) and pops it when it issues. An empty queue
// presents an all-zero bubble on rData. almost_full feeds the stall detector
// so ID can freeze before entries are lost. A push that cannot be accepted
// leaves a sticky overflow flag that only reset clears.

module id_ex_fifo #(
  parameter int DATA_W    = 256,
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = DEPTH - 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wData,
  output logic                     full,
  output logic                     almost_full,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rData,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     flush,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Entry storage; contents are left uninitialised because count decides
  // what is valid and the empty case forces a bubble on rData.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0] rp;
  logic [AW-1:0] wp;
  logic          push_ok;
  logic          pop_ok;

  // Status flags are plain decodes of the occupancy register.
  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= CW'(AFULL_LVL));

  // A pop on an empty queue is ignored. A push into a full queue is still
  // accepted when a real pop frees the head slot in the same cycle.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Show-ahead head: depends only on registers, so EX never sees a
  // combinational path from push/pop/wData.
  assign rData = empty ? '0 : mem[rp];

  // Write the incoming entry at the tail; a flush discards it.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wp] <= wData;
    end
  end

  // Pointer and occupancy bookkeeping; flush takes priority over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
    end else if (flush) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        wp <= wp + AW'(1);
      end
      if (pop_ok) begin
        rp <= rp + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error for a push that was dropped; survives flush, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (push && !push_ok) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_fifo.sv
// tb_id_ex_fifo: directed self-checking bench for id_ex_fifo (DEPTH=4).

module tb_id_ex_fifo;

  localparam int DW = 256;

  logic          clk;
  logic          rst;
  logic          push;
  logic [DW-1:0] wData;
  logic          full;
  logic          almost_full;
  logic          pop;
  logic [DW-1:0] rData;
  logic          empty;
  logic [2:0]    count;
  logic          flush;
  logic          overflow;

  int checksTotal;
  int checksPassed;

  logic [DW-1:0] model [$];

  id_ex_fifo #(.DATA_W(DW), .DEPTH(4), .AFULL_LVL(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .wData       (wData),
    .full        (full),
    .almost_full (almost_full),
    .pop         (pop),
    .rData       (rData),
    .empty       (empty),
    .count       (count),
    .flush       (flush),
    .overflow    (overflow)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value and count it.
  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    checksTotal++;
    if (observed === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then idle the inputs.
  task automatic applyStimulus(input logic p, input logic [DW-1:0] d,
                               input logic po, input logic f);
    push  = p;
    wData = d;
    pop   = po;
    flush = f;
    @(posedge clk);
    #1;
    push  = 1'b0;
    wData = '0;
    pop   = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    checksTotal  = 0;
    checksPassed = 0;
    rst   = 1'b1;
    push  = 1'b0;
    wData = '0;
    pop   = 1'b0;
    flush = 1'b0;

    // Reset state.
    #12;
    checkOutput("reset_empty",  DW'(empty),       DW'(1));
    checkOutput("reset_full",   DW'(full),        DW'(0));
    checkOutput("reset_afull",  DW'(almost_full), DW'(0));
    checkOutput("reset_count",  DW'(count),       DW'(0));
    checkOutput("reset_rdata",  rData,            DW'(0));
    checkOutput("reset_ovf",    DW'(overflow),    DW'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Mid-run asynchronous reset with three entries held.
    applyStimulus(1'b1, DW'(8'h11), 1'b0, 1'b0);
    applyStimulus(1'b1, DW'(8'h12), 1'b0, 1'b0);
    applyStimulus(1'b1, DW'(8'h13), 1'b0, 1'b0);
    checkOutput("prereset_count", DW'(count), DW'(3));
    checkOutput("prereset_head",  rData,      DW'(8'h11));
    rst = 1'b1;
    #1;
    checkOutput("async_rst_empty", DW'(empty), DW'(1));
    checkOutput("async_rst_count", DW'(count), DW'(0));
    checkOutput("async_rst_rdata", rData,      DW'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("pop_empty_count", DW'(count), DW'(0));
    checkOutput("pop_empty_flag",  DW'(empty), DW'(1));
    checkOutput("pop_empty_ovf",   DW'(overflow), DW'(0));

    // Fill with A1..A4.
    applyStimulus(1'b1, DW'(8'hA1), 1'b0, 1'b0);
    checkOutput("fill1_count", DW'(count),       DW'(1));
    checkOutput("fill1_afull", DW'(almost_full), DW'(0));
    checkOutput("fill1_head",  rData,            DW'(8'hA1));
    applyStimulus(1'b1, DW'(8'hA2), 1'b0, 1'b0);
    checkOutput("fill2_afull", DW'(almost_full), DW'(0));
    applyStimulus(1'b1, DW'(8'hA3), 1'b0, 1'b0);
    checkOutput("fill3_afull", DW'(almost_full), DW'(1));
    checkOutput("fill3_full",  DW'(full),        DW'(0));
    applyStimulus(1'b1, DW'(8'hA4), 1'b0, 1'b0);
    checkOutput("fill4_full",  DW'(full),        DW'(1));
    checkOutput("fill4_count", DW'(count),       DW'(4));
    checkOutput("fill4_head",  rData,            DW'(8'hA1));

    // Full with simultaneous push B5 and pop.
    applyStimulus(1'b1, DW'(8'hB5), 1'b1, 1'b0);
    checkOutput("fullpp_count", DW'(count),    DW'(4));
    checkOutput("fullpp_ovf",   DW'(overflow), DW'(0));
    checkOutput("fullpp_head",  rData,         DW'(8'hA2));

    // Drain: A3, A4, B5, then bubble.
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("drain1_head", rData, DW'(8'hA3));
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("drain2_head", rData, DW'(8'hA4));
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("drain3_head",  rData,      DW'(8'hB5));
    checkOutput("drain3_count", DW'(count), DW'(1));
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("drain4_rdata", rData,      DW'(0));
    checkOutput("drain4_empty", DW'(empty), DW'(1));
    checkOutput("drain4_count", DW'(count), DW'(0));

    // Overflow: fill, then push C0 without pop.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, DW'(8'hC0 + i), 1'b0, 1'b0);
    end
    applyStimulus(1'b1, DW'(8'hC0), 1'b0, 1'b0);
    checkOutput("ovf_flag",  DW'(overflow), DW'(1));
    checkOutput("ovf_count", DW'(count),    DW'(4));
    checkOutput("ovf_head",  rData,         DW'(8'hC1));
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("ovf_flush_flag",  DW'(overflow), DW'(1));
    checkOutput("ovf_flush_count", DW'(count),    DW'(0));
    checkOutput("ovf_flush_rdata", rData,         DW'(0));
    rst = 1'b1;
    #1;
    checkOutput("ovf_rst_flag", DW'(overflow), DW'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Push and pop together while empty: pop ignored, push accepted.
    applyStimulus(1'b1, DW'(8'hD1), 1'b1, 1'b0);
    checkOutput("emptypp_head",  rData,      DW'(8'hD1));
    checkOutput("emptypp_count", DW'(count), DW'(1));
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("emptypp_drain", DW'(empty), DW'(1));

    // Wrap: prime two entries, then ten push/pop pairs against a queue model.
    model = {};
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, DW'(16'hF000 + i), 1'b0, 1'b0);
      model.push_back(DW'(16'hF000 + i));
    end
    for (int i = 2; i < 12; i++) begin
      applyStimulus(1'b1, DW'(16'hF000 + i), 1'b1, 1'b0);
      void'(model.pop_front());
      model.push_back(DW'(16'hF000 + i));
      checkOutput($sformatf("wrap%0d_head", i), rData, model[0]);
      checkOutput($sformatf("wrap%0d_count", i), DW'(count), DW'(model.size()));
    end

    // Flush with a same-cycle push of E7 and a pop.
    applyStimulus(1'b1, DW'(8'hE7), 1'b1, 1'b1);
    checkOutput("flush_count", DW'(count), DW'(0));
    checkOutput("flush_rdata", rData,      DW'(0));
    checkOutput("flush_empty", DW'(empty), DW'(1));
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("flush_no_e7", rData,      DW'(0));
    applyStimulus(1'b1, DW'(8'h77), 1'b0, 1'b0);
    checkOutput("postflush_head", rData, DW'(8'h77));

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
